mux_rr_arbiter: RTL and testbench

- Shares one W-bit output channel between N_REQ requesters, each with a valid/ready handshake.
- Round-robin arbitration selects the requester; the N:1 mux picks its data into a one-entry registered output stage.
- Sits in front of any single-consumer resource in the combinational/sequential exercise set; replaces ad-hoc fixed select wiring.

---
 rtl/mux_rr_arb_pkg.sv | 23 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 41 ++++
 rtl/mux_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_mux_rr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arb_pkg.sv
// Shared types and helpers for the round-robin N:1 mux arbiter.
// The lock state type is used only when MUX_RR_ARB_LOCK_EN is defined.
package mux_rr_arb_pkg;

  // Burst lock state: while LOCKED only the requester that opened the burst
  // may be granted.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Wrap increment for an index in the range [0, n-1].
  function automatic int unsigned next_ptr(input int unsigned idx, input int unsigned n);
    int unsigned r;
    if (idx >= n - 32'd1) begin
      r = 32'd0;
    end else begin
      r = idx + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req found by scanning
// from ptr upward, wrapping at N_REQ. Works for any N_REQ >= 2, not only
// powers of two.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_valid
);

  // Scan offsets 0..N_REQ-1 from ptr. The inner loop compares against
  // constant indices so no variable bit-select is needed.
  always_comb begin
    int   tgt;
    logic found;
    tgt       = 0;
    found     = 1'b0;
    grant     = '0;
    any_valid = |req;
    for (int k = 0; k < N_REQ; k++) begin
      tgt = int'(ptr) + k;
      if (tgt >= N_REQ) begin
        tgt = tgt - N_REQ;
      end else begin
        tgt = tgt;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (tgt == i) && req[i]) begin
          found = 1'b1;
          grant = IDX_W'(i);
        end else begin
          found = found;
        end
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter plus N:1 data mux feeding a one-entry registered
// output stage with valid/ready on both sides.
// Optional burst locking is enabled by defining MUX_RR_ARB_LOCK_EN.
module mux_rr_arbiter
  import mux_rr_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 8,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
`ifdef MUX_RR_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   req_last,
`endif
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [IDX_W-1:0]   out_sel,
  input  logic               out_ready
);

  localparam int                DW_W = $clog2(N_REQ * W);
  localparam logic [N_REQ-1:0]  ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

  logic               out_valid_q, out_valid_d;
  logic [W-1:0]       out_data_q,  out_data_d;
  logic [IDX_W-1:0]   out_sel_q,   out_sel_d;
  logic [IDX_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [N_REQ-1:0]   pick_req_s;
  logic [IDX_W-1:0]   grant_s;
  logic               any_s;
  logic               xfer_s;
  logic               last_s;
  logic [DW_W-1:0]    base_s;
  logic [W-1:0]       sel_data_s;

`ifdef MUX_RR_ARB_LOCK_EN
  lock_state_e        lock_q, lock_d;

  // While locked only the burst owner is eligible; the owner is the last
  // requester transferred, which out_sel_q still holds.
  always_comb begin
    if (lock_q == LOCKED) begin
      pick_req_s = req_valid & (ONE << out_sel_q);
    end else begin
      pick_req_s = req_valid;
    end
    last_s = req_last[grant_s];
  end
`else
  // Without locking every beat stands alone.
  always_comb begin
    pick_req_s = req_valid;
    last_s     = 1'b1;
  end
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req       (pick_req_s),
    .ptr       (rr_ptr_q),
    .grant     (grant_s),
    .any_valid (any_s)
  );

  // Grant handshake and data select; only the granted slice reaches the
  // output register so X on other requesters cannot leak through.
  always_comb begin
    xfer_s     = !rst && (!out_valid_q || out_ready) && any_s;
    base_s     = DW_W'(grant_s) * DW_W'(W);
    sel_data_s = req_data[base_s +: W];
    if (xfer_s) begin
      req_ready = ONE << grant_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state of the output stage, pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    rr_ptr_d    = rr_ptr_q;
`ifdef MUX_RR_ARB_LOCK_EN
    lock_d      = lock_q;
`endif
    if (xfer_s) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data_s;
      out_sel_d   = grant_s;
      if (last_s) begin
        rr_ptr_d = IDX_W'(next_ptr(32'(grant_s), 32'(N_REQ)));
      end else begin
        rr_ptr_d = rr_ptr_q;
      end
`ifdef MUX_RR_ARB_LOCK_EN
      lock_d = last_s ? UNLOCKED : LOCKED;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
`ifdef MUX_RR_ARB_LOCK_EN
      lock_q      <= UNLOCKED;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_RR_ARB_LOCK_EN
      lock_q      <= lock_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N_REQ=4, W=8). Compile with or
// without MUX_RR_ARB_LOCK_EN; expectations follow the build.
module tb_mux_rr_arbiter;

`ifdef MUX_RR_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  req_last;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  mux_rr_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef MUX_RR_ARB_LOCK_EN
    .req_last  (req_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: spec-level state of the output stage and arbiter.
  bit       m_valid  = 1'b0;
  bit [7:0] m_data   = 8'h00;
  int       m_sel    = 0;
  int       m_ptr    = 0;
  bit       m_locked = 1'b0;
  int       m_owner  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Requester order: ptr, ptr+1, ... modulo 4; a lock restricts to the owner.
  function automatic int model_grant(input logic [3:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // One clock: drive at negedge, check req_ready, then check registered
  // outputs 1 time unit after the rising edge.
  task automatic cycle(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic o, input logic [3:0] l, output logic [3:0] rdy);
    int g;
    logic [3:0] exp_rdy;
    rst = r; req_valid = v; req_data = d; out_ready = o; req_last = l;
    #1;
    g = (!r && (!m_valid || o)) ? model_grant(v) : -1;
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_locked = 0; m_owner = 0;
    end else if (g >= 0) begin
      m_valid = 1; m_data = d[g*8 +: 8]; m_sel = g;
      if (!LOCK_EN || l[g]) begin
        m_ptr = (g + 1) % 4; m_locked = 0;
      end else begin
        m_locked = 1; m_owner = g;
      end
    end else if (o) begin
      m_valid = 0;
    end
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_sel", 32'(out_sel), 32'(m_sel));
    chk("out_data", 32'(out_data), 32'(m_data));
    @(negedge clk);
  endtask

  // Data A0+i for valid requesters, X for the rest.
  function automatic logic [31:0] fixed_data(input logic [3:0] v);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[i*8 +: 8] = v[i] ? (8'hA0 + 8'(i)) : 8'hxx;
    return d;
  endfunction

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       oready;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [1:0] exp_sel;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [3:0]  rdy;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    int          beats;
    int          exp_seq[4];

    // reset held with all valid
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    // round robin, 8 cycles
    tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[9]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    // wrap/skip: grant 2 leaves ptr=3, then 0101 -> 0 then 2
    tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    tbl[11] = '{1'b0, 4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};
    tbl[12] = '{1'b0, 4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA2};
    // backpressure for 3 cycles, then release -> requester 3
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2};
    tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2};
    tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA2};
    tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 8'hA3};
    // drain: valid drops, sel/data hold
    tbl[17] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 8'hA3};
    // load a word, then reset while stalled, then grant restarts at 0
    tbl[18] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 8'hA1};
    tbl[19] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[20] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 8'hA0};

    rst = 1'b1; req_valid = 4'b0000; req_data = 32'h0; out_ready = 1'b0; req_last = 4'b1111;
    @(negedge clk);

    for (int t = 0; t < 21; t++) begin
      cycle(tbl[t].rst, tbl[t].valid, fixed_data(tbl[t].valid), tbl[t].oready, 4'b1111, rdy);
      chk($sformatf("tbl%0d_ready", t), 32'(rdy), 32'(tbl[t].exp_ready));
      chk($sformatf("tbl%0d_valid", t), 32'(out_valid), 32'(tbl[t].exp_valid));
      chk($sformatf("tbl%0d_sel", t), 32'(out_sel), 32'(tbl[t].exp_sel));
      chk($sformatf("tbl%0d_data", t), 32'(out_data), 32'(tbl[t].exp_data));
    end

    // Burst of 3 beats from requester 1 (last on 3rd) with 0 and 2 valid.
    if (LOCK_EN) exp_seq = '{1, 1, 1, 2};
    else         exp_seq = '{1, 2, 0, 1};
    beats = 0;
    for (int t = 0; t < 4; t++) begin
      v = 4'b0101 | ((beats < 3) ? 4'b0010 : 4'b0000);
      l = 4'b1101 | ((beats == 2) ? 4'b0010 : 4'b0000);
      cycle(1'b0, v, fixed_data(v), 1'b1, l, rdy);
      chk($sformatf("lock_seq%0d", t), 32'(out_sel), 32'(exp_seq[t]));
      if (rdy[1]) beats++;
    end

    // Randomized traffic against the model.
    for (int t = 0; t < 600; t++) begin
      v = 4'($urandom);
      l = 4'($urandom);
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = v[i] ? 8'($urandom) : 8'hxx;
      cycle(($urandom_range(0, 63) == 0), v, d, ($urandom_range(0, 3) != 0), l, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
